bg_trim_ctrl: RTL and testbench
===============================

Name: bg_trim_ctrl

Overview:
- Clocked controller that powers up and trims the bandgap core.
- Sequences the switched-capacitor sample/share/compare phases: diode select, c1/c2 switches, comparator zero and swap.
- Runs an 8-bit successive-approximation search on idacFine, using the comparator output with chopped offset cancellation.
- Drives all digital inputs of the bandgap core and reports the final trim code to the top-level register file.

Parameters:
- PWRUP_CYCLES, 64: clocks from pwrup assertion to first phase (analog settle).
- SETTLE_CYCLES, 16: clocks per phase; legal range 4..255.
- COARSE_DEFAULT, 8'h10: idacCoarse value driven while idle after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high; one clock.
- start  input  1  single-cycle request to begin a trim; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE with pwrup=0.
- coarseIn  input  8  idacCoarse value latched on accepted start.
- cmpo  input  1  comparator output (CMPO), asynchronous to clk.
- pwrup  output  1  core power-up.
- idacFine  output  8  fine IDAC code (SAR trial / final).
- idacCoarse  output  8  coarse IDAC code.
- idacOutSelect_n  output  4  IDAC output enables, active-low.
- diodeSelect  output  8  diode bank select.
- resStableSelect  output  1  stable-current resistor select.
- resPtatEnable_n  output  1  PTAT resistor enable, active-low.
- c1, c2  output  2 each  cap cell switches: bit0=CA (to VD), bit1=CB (to VP/VN).
- cmpZeroOffset  output  1  comparator auto-zero.
- cmpSwapInput  output  1  comparator input swap (chop).
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at trim completion.
- trim  output  8  last completed trim code.

Behaviour:
- Reset values:
  - pwrup=0, idacFine=8'h80, idacCoarse=COARSE_DEFAULT, idacOutSelect_n=4'b1111, diodeSelect=8'h00.
  - resStableSelect=0, resPtatEnable_n=1, c1=c2=2'b00, cmpZeroOffset=0, cmpSwapInput=0.
  - busy=0, done=0, trim=8'h80. State IDLE.
- cmpo passes through a 2-flop synchronizer. The decision uses the synchronized value at the last cycle of COMPARE.
- States and transitions (one shared phase counter; each timed phase lasts SETTLE_CYCLES):
  - IDLE:
    - Outputs hold.
    - start && !abort: latch coarseIn into idacCoarse, set pwrup=1, resPtatEnable_n=0, idacOutSelect_n=4'b1110, idacFine=8'h80, bit index k=7, busy=1, go to PWRUP.
  - PWRUP: wait PWRUP_CYCLES, then go to ZERO.
  - ZERO: cmpZeroOffset=1, c1=c2=2'b11. Then go to SAMPLE1 with cmpSwapInput=0.
  - SAMPLE1: diodeSelect=8'h01, c1=2'b01, c2=2'b00.
  - SAMPLE2: diodeSelect=8'hFF, c1=2'b00, c2=2'b01.
  - SHARE: diodeSelect=8'h00, c1=2'b10, c2=2'b10.
  - COMPARE: c1=c2=2'b00. Record the decision as dA (swap=0) or dB (swap=1).
    - If swap=0: set swap=1, go to SAMPLE1.
    - If swap=1: go to UPDATE.
  - UPDATE (1 cycle):
    - Bit k of idacFine stays 1 iff dA==1 && dB==0; otherwise cleared.
    - If k>0: set bit k-1, k=k-1, swap=0, go to SAMPLE1.
    - If k==0: go to FINISH.
  - FINISH (1 cycle):
    - trim<=idacFine, idacOutSelect_n=4'b1101 (IOUT enabled), resStableSelect=1.
    - busy=0, done=1 for exactly this cycle. Go to IDLE; pwrup stays 1.
- Latency: done is high exactly PWRUP_CYCLES + 65*SETTLE_CYCLES + 8 + 1 cycles after the edge that accepts start (1113 with defaults).
- Boundary and error conditions:
  - start while busy: ignored, no effect.
  - start and abort in the same IDLE cycle: abort wins, start dropped.
  - abort in any non-IDLE state: next cycle IDLE.
    - pwrup=0, c1=c2=2'b00, diodeSelect=0, cmpZeroOffset=0, cmpSwapInput=0, idacOutSelect_n=4'b1111, busy=0.
    - No done pulse; trim unchanged.
  - Reset mid-trim: immediate return to reset values, including trim=8'h80.
  - Switch safety:
    - c1 and c2 never have CA and CB both 1, except in ZERO.
    - All switches are 0 in the first cycle of every phase (break-before-make), so each phase has SETTLE_CYCLES-1 active cycles.
  - SAR codes 8'h00 and 8'hFF are reachable. No wrap-around; no 9th bit.
  - A new start after done restarts from idacFine=8'h80 regardless of trim.

Test Plan:
- Reset then idle 100 cycles -> all outputs at reset values, busy=0, done never pulses.
- start with coarseIn=8'h22; cmpo model returns 1 (swap=0) / 0 (swap=1) iff idacFine<=8'h5A -> done at cycle 1113, trim=8'h5A, idacCoarse=8'h22, idacOutSelect_n=4'b1101, pwrup=1.
- cmpo stuck 1 in both swap states (pure offset) -> every bit cleared, trim=8'h00; cmpo always "correct" (1/0) -> trim=8'hFF.
- abort 500 cycles after start -> next cycle pwrup=0, busy=0, all switches 0, no done, trim keeps previous value; start again -> full sequence completes normally.
- start re-pulsed while busy, and start with abort in the same cycle -> no restart; done timing unchanged / nothing starts.
- Assert reset during SHARE of bit 3 -> outputs return to reset values asynchronously. Switch-safety assertion (CA&CB only in ZERO, break-before-make gap) holds throughout all runs.

Source files
------------

// File: rtl/bg_trim_ctrl.sv
// Bandgap power-up and trim sequencer: steps the switched-capacitor phases and
// runs an 8-bit chopped SAR search on idacFine, reporting the result on trim.
module bg_trim_ctrl #(
  parameter int         PWRUP_CYCLES   = 64,
  parameter int         SETTLE_CYCLES  = 16,
  parameter logic [7:0] COARSE_DEFAULT = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] coarseIn,
  input  logic       cmpo,
  output logic       pwrup,
  output logic [7:0] idacFine,
  output logic [7:0] idacCoarse,
  output logic [3:0] idacOutSelect_n,
  output logic [7:0] diodeSelect,
  output logic       resStableSelect,
  output logic       resPtatEnable_n,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic       cmpZeroOffset,
  output logic       cmpSwapInput,
  output logic       busy,
  output logic       done,
  output logic [7:0] trim
);

  localparam logic [15:0] PWRUP_LAST  = 16'(PWRUP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PWRUP, ST_ZERO, ST_SAMPLE1, ST_SAMPLE2,
    ST_SHARE, ST_COMPARE, ST_UPDATE, ST_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  sync_q, sync_d;
  logic        swap_q, swap_d, d_a_q, d_a_d, d_b_q, d_b_d;
  logic        pwrup_q, pwrup_d, res_stable_q, res_stable_d, ptat_n_q, ptat_n_d;
  logic        zero_q, zero_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  fine_q, fine_d, coarse_q, coarse_d, diode_q, diode_d, trim_q, trim_d;
  logic [3:0]  sel_n_q, sel_n_d;
  logic [1:0]  c1_q, c1_d, c2_q, c2_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    bit_d        = bit_q;
    sync_d       = {sync_q[0], cmpo};
    swap_d       = swap_q;
    d_a_d        = d_a_q;
    d_b_d        = d_b_q;
    pwrup_d      = pwrup_q;
    res_stable_d = res_stable_q;
    ptat_n_d     = ptat_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fine_d       = fine_q;
    coarse_d     = coarse_q;
    trim_d       = trim_q;
    sel_n_d      = sel_n_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d  = ST_PWRUP;
          coarse_d = coarseIn;
          pwrup_d  = 1'b1;
          ptat_n_d = 1'b0;
          sel_n_d  = 4'b1110;
          fine_d   = 8'h80;
          bit_d    = 3'd7;
          swap_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_PWRUP: if (cnt_q == PWRUP_LAST) begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
      ST_ZERO: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_SAMPLE1;
        cnt_d   = '0;
        swap_d  = 1'b0;
      end
      ST_SAMPLE1: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_SAMPLE2;
        cnt_d   = '0;
      end
      ST_SAMPLE2: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_SHARE;
        cnt_d   = '0;
      end
      ST_SHARE: if (cnt_q == SETTLE_LAST) begin
        state_d = ST_COMPARE;
        cnt_d   = '0;
      end
      // The first pass decides with normal inputs, the second with swapped ones.
      ST_COMPARE: if (cnt_q == SETTLE_LAST) begin
        cnt_d = '0;
        if (!swap_q) begin
          d_a_d   = sync_q[1];
          swap_d  = 1'b1;
          state_d = ST_SAMPLE1;
        end else begin
          d_b_d   = sync_q[1];
          state_d = ST_UPDATE;
        end
      end
      // A bit survives only when the chopped pair agrees, cancelling comparator offset.
      ST_UPDATE: begin
        cnt_d          = '0;
        fine_d[bit_q]  = d_a_q & ~d_b_q;
        if (bit_q != 3'd0) begin
          fine_d[bit_q - 3'd1] = 1'b1;
          bit_d   = bit_q - 3'd1;
          swap_d  = 1'b0;
          state_d = ST_SAMPLE1;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        cnt_d        = '0;
        trim_d       = fine_q;
        sel_n_d      = 4'b1101;
        res_stable_d = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pwrup_d = 1'b0;
      sel_n_d = 4'b1111;
      swap_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      trim_d  = trim_q;
    end
  end

  // Switch drive follows the next phase; a zero count forces the break-before-make gap.
  always_comb begin
    c1_d    = 2'b00;
    c2_d    = 2'b00;
    diode_d = 8'h00;
    zero_d  = 1'b0;
    unique case (state_d)
      ST_ZERO: begin
        zero_d = 1'b1;
        if (cnt_d != 16'd0) begin
          c1_d = 2'b11;
          c2_d = 2'b11;
        end
      end
      ST_SAMPLE1: begin
        diode_d = 8'h01;
        if (cnt_d != 16'd0) c1_d = 2'b01;
      end
      ST_SAMPLE2: begin
        diode_d = 8'hFF;
        if (cnt_d != 16'd0) c2_d = 2'b01;
      end
      ST_SHARE: if (cnt_d != 16'd0) begin
        c1_d = 2'b10;
        c2_d = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd7;
      sync_q       <= 2'b00;
      swap_q       <= 1'b0;
      d_a_q        <= 1'b0;
      d_b_q        <= 1'b0;
      pwrup_q      <= 1'b0;
      res_stable_q <= 1'b0;
      ptat_n_q     <= 1'b1;
      zero_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fine_q       <= 8'h80;
      coarse_q     <= COARSE_DEFAULT;
      diode_q      <= 8'h00;
      trim_q       <= 8'h80;
      sel_n_q      <= 4'b1111;
      c1_q         <= 2'b00;
      c2_q         <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sync_q       <= sync_d;
      swap_q       <= swap_d;
      d_a_q        <= d_a_d;
      d_b_q        <= d_b_d;
      pwrup_q      <= pwrup_d;
      res_stable_q <= res_stable_d;
      ptat_n_q     <= ptat_n_d;
      zero_q       <= zero_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fine_q       <= fine_d;
      coarse_q     <= coarse_d;
      diode_q      <= diode_d;
      trim_q       <= trim_d;
      sel_n_q      <= sel_n_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
    end
  end

  assign pwrup           = pwrup_q;
  assign idacFine        = fine_q;
  assign idacCoarse      = coarse_q;
  assign idacOutSelect_n = sel_n_q;
  assign diodeSelect     = diode_q;
  assign resStableSelect = res_stable_q;
  assign resPtatEnable_n = ptat_n_q;
  assign c1              = c1_q;
  assign c2              = c2_q;
  assign cmpZeroOffset   = zero_q;
  assign cmpSwapInput    = swap_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign trim            = trim_q;

endmodule

// File: tb/tb_bg_trim_ctrl.sv
// Randomized scoreboard bench for bg_trim_ctrl with an analog comparator model
// and an idealized SAR reference.
module tb_bg_trim_ctrl;

  localparam int LATENCY = 64 + 65 * 16 + 8 + 1;

  logic       clk = 1'b0;
  logic       reset, start, abort, cmpo;
  logic [7:0] coarseIn;
  logic       pwrup, resStableSelect, resPtatEnable_n, cmpZeroOffset, cmpSwapInput, busy, done;
  logic [7:0] idacFine, idacCoarse, diodeSelect, trim;
  logic [3:0] idacOutSelect_n;
  logic [1:0] c1, c2;

  bg_trim_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .coarseIn(coarseIn), .cmpo(cmpo),
    .pwrup(pwrup), .idacFine(idacFine), .idacCoarse(idacCoarse),
    .idacOutSelect_n(idacOutSelect_n), .diodeSelect(diodeSelect),
    .resStableSelect(resStableSelect), .resPtatEnable_n(resPtatEnable_n),
    .c1(c1), .c2(c2), .cmpZeroOffset(cmpZeroOffset), .cmpSwapInput(cmpSwapInput),
    .busy(busy), .done(done), .trim(trim)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] trim;
    logic [7:0] coarse;
    int         done_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  int         sw_viol = 0;
  logic [3:0] sw_prev = 4'h0;
  int         mode = 0;
  logic [7:0] target = 8'h00;
  logic [7:0] last_trim = 8'h80;
  logic [7:0] last_coarse = 8'h10;

  // Comparator: 0 ideal against target, 1 stuck high, 2 stuck low.
  function automatic logic cmp_model(input logic [7:0] fine, input logic swap, input int m,
                                     input logic [7:0] t);
    case (m)
      0:       return (fine <= t) ^ swap;
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign cmpo = cmp_model(idacFine, cmpSwapInput, mode, target);

  // Binary search from the MSB: keep a trial bit when the chopped decisions agree.
  function automatic logic [7:0] sar_reference(input int m, input logic [7:0] t);
    logic [7:0] code, trial;
    code = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      trial = code | (8'd1 << k);
      if (cmp_model(trial, 1'b0, m, t) && !cmp_model(trial, 1'b1, m, t)) code = trial;
    end
    return code;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every done pulse and tracks switch safety.
  always @(negedge clk) begin
    if (reset) begin
      sw_prev = 4'h0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("trim", trim, mon_e.trim);
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
          checkOutput("coarse", idacCoarse, mon_e.coarse);
          checkOutput("outsel_done", idacOutSelect_n, 4'b1101);
          checkOutput("pwrup_done", pwrup, 1);
          checkOutput("busy_done", busy, 0);
          checkOutput("res_stable_done", resStableSelect, 1);
          last_trim = mon_e.trim;
        end
      end
      if ((c1 == 2'b11 || c2 == 2'b11) && !cmpZeroOffset) sw_viol++;
      if (sw_prev != 4'h0 && {c1, c2} != 4'h0 && {c1, c2} != sw_prev) sw_viol++;
      sw_prev = {c1, c2};
    end
  end

  task automatic applyStimulus(input logic [7:0] coarse, input int m, input logic [7:0] t,
                               input bit expect_done);
    exp_t e;
    @(negedge clk);
    mode     = m;
    target   = t;
    start    = 1'b1;
    coarseIn = coarse;
    if (expect_done) begin
      e.trim     = sar_reference(m, t);
      e.coarse   = coarse;
      e.done_cyc = cyc + 1 + LATENCY;
      sb.push_back(e);
    end
    last_coarse = coarse;
    @(negedge clk);
    start    = 1'b0;
    coarseIn = 8'h00;
  endtask

  task automatic waitDone();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_arrived", sb.size(), 0);
    sb.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pwrup"}, pwrup, 0);
    checkOutput({tag, "_fine"}, idacFine, 8'h80);
    checkOutput({tag, "_coarse"}, idacCoarse, 8'h10);
    checkOutput({tag, "_outsel"}, idacOutSelect_n, 4'b1111);
    checkOutput({tag, "_diode"}, diodeSelect, 8'h00);
    checkOutput({tag, "_resstable"}, resStableSelect, 0);
    checkOutput({tag, "_ptat_n"}, resPtatEnable_n, 1);
    checkOutput({tag, "_c1"}, c1, 2'b00);
    checkOutput({tag, "_c2"}, c2, 2'b00);
    checkOutput({tag, "_zero"}, cmpZeroOffset, 0);
    checkOutput({tag, "_swap"}, cmpSwapInput, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_trim"}, trim, 8'h80);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    coarseIn = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checkResetValues("reset");

    applyStimulus(8'h22, 0, 8'h5A, 1);
    waitDone();
    applyStimulus(8'h01, 1, 8'h77, 1);
    waitDone();
    applyStimulus(8'hF0, 0, 8'hFF, 1);
    waitDone();
    applyStimulus(8'h0F, 0, 8'h00, 1);
    waitDone();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
                    8'($urandom_range(0, 255)), 1);
      waitDone();
    end

    // A second start while busy must not disturb coarse code or timing.
    applyStimulus(8'h33, 0, 8'hA7, 1);
    repeat (300) @(negedge clk);
    start    = 1'b1;
    coarseIn = 8'hEE;
    @(negedge clk);
    start    = 1'b0;
    coarseIn = 8'h00;
    waitDone();

    applyStimulus(8'h44, 0, 8'h3C, 0);
    repeat (500) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_pwrup", pwrup, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_c1", c1, 2'b00);
    checkOutput("abort_c2", c2, 2'b00);
    checkOutput("abort_diode", diodeSelect, 8'h00);
    checkOutput("abort_zero", cmpZeroOffset, 0);
    checkOutput("abort_swap", cmpSwapInput, 0);
    checkOutput("abort_outsel", idacOutSelect_n, 4'b1111);
    checkOutput("abort_trim", trim, last_trim);
    repeat (1200) @(negedge clk);

    applyStimulus(8'h66, 0, 8'h96, 1);
    waitDone();

    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    coarseIn = 8'h99;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    coarseIn = 8'h00;
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_coarse", idacCoarse, last_coarse);
    repeat (1200) @(negedge clk);
    checkOutput("start_abort_idle", busy, 0);

    // Bit 3 first SHARE phase begins 628 cycles after the accepting edge.
    applyStimulus(8'h55, 0, 8'hC3, 1);
    repeat (629) @(negedge clk);
    checkOutput("share_c1", c1, 2'b10);
    checkOutput("share_c2", c2, 2'b10);
    checkOutput("share_swap", cmpSwapInput, 0);
    #2 reset = 1'b1;
    #1 checkResetValues("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(8'h77, 0, 8'h1D, 1);
    waitDone();

    checkOutput("switch_safety", sw_viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
